// File: rtl/mmio_input_port.sv
`default_nettype none
// ==================================================================================
// mmio_input_port: synchronized switches and debounced keys with a W1C press register.
// Optional MMIO_INPUT_IRQ_EN adds a key mask register and irq.  Rev 1.0
// ==================================================================================
module mmio_input_port #(
  parameter int          NUM_SW          = 10,
  parameter int          NUM_KEY         = 4,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] SW_ADDR         = 32'hFFFFFFF8,
  parameter logic [31:0] KEY_ADDR        = 32'hFFFFFFF4,
  parameter logic [31:0] EDGE_ADDR       = 32'hFFFFFFF0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SW-1:0]  SW,
  input  logic [NUM_KEY-1:0] KEY,
  input  logic [31:0]        addr,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               hit,
  output logic               irq
);

  localparam int                CNT_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]       MASK_ADDR = 32'hFFFFFFEC;

  logic [NUM_SW-1:0]  sw_sync1_q, sw_q;
  logic [NUM_KEY-1:0] key_sync1_q, key_sync2_q;
  logic [NUM_KEY-1:0] key_s, key_db_q, key_db_d, accept, rise;
  logic [NUM_KEY-1:0] edge_cap_q, edge_cap_d, edge_clr;
  logic               unused_wr_data;

  assign key_s          = ~key_sync2_q;
  assign unused_wr_data = ^wr_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_sync1_q  <= '0;
      sw_q        <= '0;
      key_sync1_q <= '1;
      key_sync2_q <= '1;
    end else begin
      sw_sync1_q  <= SW;
      sw_q        <= sw_sync1_q;
      key_sync1_q <= KEY;
      key_sync2_q <= key_sync1_q;
    end
  end

  // Each key owns a counter; any return to the accepted level restarts it from zero.
  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
    logic [CNT_W-1:0] cnt_q;
    assign accept[i] = (key_s[i] != key_db_q[i]) && (cnt_q == CNT_MAX);
    always_ff @(posedge clk) begin
      if (!reset_n || key_s[i] == key_db_q[i] || accept[i]) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign key_db_d   = key_db_q ^ accept;
  assign rise       = accept & key_s;
  assign edge_clr   = (wr_en && addr == EDGE_ADDR) ? wr_data[NUM_KEY-1:0] : '0;
  // Set is ORed in after the clear so a press in the clearing cycle survives.
  assign edge_cap_d = (edge_cap_q & ~edge_clr) | rise;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_db_q   <= '0;
      edge_cap_q <= '0;
    end else begin
      key_db_q   <= key_db_d;
      edge_cap_q <= edge_cap_d;
    end
  end

`ifdef MMIO_INPUT_IRQ_EN
  logic [NUM_KEY-1:0] mask_q;
  logic               irq_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && addr == MASK_ADDR) mask_q <= wr_data[NUM_KEY-1:0];
      irq_q <= |(edge_cap_q & mask_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    hit     = 1'b0;
    rd_data = '0;
    if (addr == SW_ADDR) begin
      hit                 = 1'b1;
      rd_data[NUM_SW-1:0] = sw_q;
    end else if (addr == KEY_ADDR) begin
      hit                  = 1'b1;
      rd_data[NUM_KEY-1:0] = key_db_q;
    end else if (addr == EDGE_ADDR) begin
      hit                  = 1'b1;
      rd_data[NUM_KEY-1:0] = edge_cap_q;
    end
`ifdef MMIO_INPUT_IRQ_EN
    else if (addr == MASK_ADDR) begin
      hit                  = 1'b1;
      rd_data[NUM_KEY-1:0] = mask_q;
    end
`endif
    if (!rd_en) rd_data = '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_input_port.sv
`default_nettype none
// Directed bench for mmio_input_port with a short debounce window (4 cycles).
module tb_mmio_input_port;

  localparam logic [31:0] SW_A   = 32'hFFFFFFF8;
  localparam logic [31:0] KEY_A  = 32'hFFFFFFF4;
  localparam logic [31:0] EDGE_A = 32'hFFFFFFF0;
  localparam logic [31:0] MASK_A = 32'hFFFFFFEC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [31:0] addr, wr_data, rd_data;
  logic        rd_en, wr_en, hit, irq;
  int          checks = 0;
  int          failures = 0;

  mmio_input_port #(.NUM_SW(10), .NUM_KEY(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .SW(SW), .KEY(KEY), .addr(addr),
    .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data(rd_data), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    #1;
    check(tag, rd_data, exp);
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; wr_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; SW = 10'h2A5; KEY = 4'hF;
    addr = '0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
    tick(2);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    rd(SW_A, 32'h0, "sw_after_rst");
    tick();
    rd(SW_A, 32'h0, "sw_1clk");
    tick();
    rd(SW_A, 32'h2A5, "sw_2clk");
    rd(KEY_A, 32'h0, "key_rst");
    rd(EDGE_A, 32'h0, "edge_rst");

    // KEY[1] pressed and held: accepted on the 6th edge
    KEY = 4'b1101;
    tick(5);
    rd(KEY_A, 32'h0, "key1_5clk");
    tick();
    rd(KEY_A, 32'h2, "key1_6clk");
    rd(EDGE_A, 32'h2, "edge1_set");

    // KEY[0] low for only 3 clk
    KEY = 4'b1100;
    tick(3);
    KEY = 4'b1101;
    tick(8);
    rd(KEY_A, 32'h2, "glitch_key");
    rd(EDGE_A, 32'h2, "glitch_edge");

    // KEY[0] held: edge_cap = 0011, then clear bit 0
    KEY = 4'b1100;
    tick(6);
    rd(EDGE_A, 32'h3, "edge_0011");
    wr(EDGE_A, 32'h1);
    rd(EDGE_A, 32'h2, "w1c_bit0");
    rd(KEY_A, 32'h3, "key_both");

    addr = EDGE_A; wr_data = 32'hFFFFFFFF; wr_en = 1'b0;
    tick();
    rd(EDGE_A, 32'h2, "wr_en0_noeffect");

    // Release KEY[1]: no edge; then clear it
    KEY = 4'b1110;
    tick(6);
    rd(KEY_A, 32'h1, "key1_release");
    rd(EDGE_A, 32'h2, "release_ignored");
    wr(EDGE_A, 32'h2);
    rd(EDGE_A, 32'h0, "w1c_bit1");

    // Re-press KEY[1] with a clear landing on the accepting edge
    KEY = 4'b1100;
    tick(5);
    rd(KEY_A, 32'h1, "collide_pre");
    wr(EDGE_A, 32'h2);
    rd(KEY_A, 32'h3, "collide_key");
    rd(EDGE_A, 32'h2, "collide_set_wins");

    // Decode
    addr = SW_A; wr_data = 32'hFFFFFFFF; wr_en = 1'b1;
    #1;
    check("hit_sw_store", {31'd0, hit}, 32'd1);
    tick();
    addr = KEY_A;
    tick();
    wr_en = 1'b0;
    rd(SW_A, 32'h2A5, "sw_store_ign");
    rd(KEY_A, 32'h3, "key_store_ign");
    rd(EDGE_A, 32'h2, "edge_after_ro");
    addr = 32'hFFFFFFFC; rd_en = 1'b1;
    #1;
    check("unmapped_hit", {31'd0, hit}, 32'd0);
    check("unmapped_rd", rd_data, 32'd0);
    addr = SW_A; rd_en = 1'b0;
    #1;
    check("rden0_rd", rd_data, 32'd0);
    check("rden0_hit", {31'd0, hit}, 32'd1);

`ifdef MMIO_INPUT_IRQ_EN
    wr(EDGE_A, 32'hF);
    wr(MASK_A, 32'hFFFFFF04);
    rd(MASK_A, 32'h4, "mask_rd");
    KEY = 4'b1000;
    tick(6);
    rd(EDGE_A, 32'h4, "edge2_set");
    check("irq_same_clk", {31'd0, irq}, 32'd0);
    tick();
    check("irq_asserted", {31'd0, irq}, 32'd1);
    KEY = 4'b0000;
    tick(7);
    rd(EDGE_A, 32'hC, "edge3_set");
    check("irq_key3_masked", {31'd0, irq}, 32'd1);
    wr(EDGE_A, 32'h4);
    rd(EDGE_A, 32'h8, "edge2_clr");
    check("irq_hold_1clk", {31'd0, irq}, 32'd1);
    tick();
    check("irq_deasserted", {31'd0, irq}, 32'd0);
`else
    addr = MASK_A; rd_en = 1'b1;
    #1;
    check("mask_unmapped_hit", {31'd0, hit}, 32'd0);
    check("mask_unmapped_rd", rd_data, 32'd0);
    rd_en = 1'b0;
    check("irq_tied0", {31'd0, irq}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
